// File: rtl/signed_acc_pkg.sv
// Shared widths, saturation limits and FSM state type for the signed accumulator stages.
package signed_acc_pkg;

   localparam int unsigned DATA_W = 8;
   localparam logic signed [DATA_W-1:0] SMAX = 8'sh7F;
   localparam logic signed [DATA_W-1:0] SMIN = 8'sh80;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      ACC,
      HOLD
   } state_e;

endpackage

// File: rtl/signed_frame_accumulator_if.sv
// Valid/ready sample input and frame-result output bundle of the signed frame accumulator.
interface signed_frame_accumulator_if
   import signed_acc_pkg::*;
();

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_sum;
   logic                     out_ovf;
   logic [CNT_W-1:0]         out_ovf_cnt;

   // Environment side: feeds samples and consumes results.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_ovf_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_ovf_cnt
   );

endinterface

// File: rtl/sat_add8.sv
// Combinational 8-bit signed adder that clamps to the representable range on overflow.
module sat_add8
   import signed_acc_pkg::*;
(
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] sum,
   output logic                     ovf
);

   logic [DATA_W:0] wide;

   assign wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
   // Sign-extended 9-bit sum disagrees in its top two bits exactly when the 8-bit result wrapped.
   assign ovf  = wide[DATA_W] ^ wide[DATA_W-1];
   assign sum  = ovf ? (wide[DATA_W] ? SMIN : SMAX) : wide[DATA_W-1:0];

endmodule

// File: rtl/signed_frame_accumulator.sv
// Sums frames of FRAME_LEN signed samples with saturation and presents total plus overflow stats.
module signed_frame_accumulator
   import signed_acc_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 4
) (
   input logic                        clk,
   input logic                        rst_n,
   input logic                        clear,
   signed_frame_accumulator_if.slave  bus
);

   localparam int unsigned IDX_W = 8;

   state_e                   state_q, state_d;
   logic signed [DATA_W-1:0] acc_q, acc_d;
   logic                     ovf_q, ovf_d;
   logic [CNT_W-1:0]         ovf_cnt_q, ovf_cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [DATA_W-1:0] out_sum_q, out_sum_d;
   logic                     out_ovf_q, out_ovf_d;
   logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;

   logic signed [DATA_W-1:0] step_sum;
   logic                     step_ovf;
   logic [CNT_W-1:0]         step_cnt;
   logic                     last_sample;

   sat_add8 u_sat_add8 (
      .a   (acc_q),
      .b   (bus.in_data),
      .sum (step_sum),
      .ovf (step_ovf)
   );

   assign step_cnt    = (step_ovf && (ovf_cnt_q != CNT_MAX)) ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;
   assign last_sample = (idx_q == IDX_W'(FRAME_LEN - 1));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      idx_d     = idx_q;
      out_sum_d = out_sum_q;
      out_ovf_d = out_ovf_q;
      out_cnt_d = out_cnt_q;

      unique case (state_q)
         ACC: begin
            if (bus.in_valid) begin
               acc_d     = step_sum;
               ovf_d     = ovf_q | step_ovf;
               ovf_cnt_d = step_cnt;
               idx_d     = idx_q + IDX_W'(1);
               if (last_sample) begin
                  out_sum_d = step_sum;
                  out_ovf_d = ovf_q | step_ovf;
                  out_cnt_d = step_cnt;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d   = ACC;
               acc_d     = '0;
               ovf_d     = 1'b0;
               ovf_cnt_d = '0;
               idx_d     = '0;
            end
         end
         default: state_d = ACC;
      endcase

      // Abort wins over any transfer happening in the same cycle.
      if (clear) begin
         state_d   = ACC;
         acc_d     = '0;
         ovf_d     = 1'b0;
         ovf_cnt_d = '0;
         idx_d     = '0;
         out_sum_d = '0;
         out_ovf_d = 1'b0;
         out_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
         idx_q     <= '0;
         out_sum_q <= '0;
         out_ovf_q <= 1'b0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
         idx_q     <= idx_d;
         out_sum_q <= out_sum_d;
         out_ovf_q <= out_ovf_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   assign bus.in_ready    = rst_n && (state_q == ACC);
   assign bus.out_valid   = (state_q == HOLD);
   assign bus.out_sum     = out_sum_q;
   assign bus.out_ovf     = out_ovf_q;
   assign bus.out_ovf_cnt = out_cnt_q;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Randomized and directed bench for signed_frame_accumulator against a frame-level reference model.
module tb_signed_frame_accumulator;

   localparam int unsigned FRAME_LEN = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;

   int tests = 0;
   int fails = 0;

   signed_frame_accumulator_if sif ();

   signed_frame_accumulator #(
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic signed [31:0] act,
                                 input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Frame total with clamping after every step, counted in plain integers.
   function automatic void fold(input int xs[$], output int s, output int n);
      s = 0;
      n = 0;
      foreach (xs[i]) begin
         s += xs[i];
         if (s > 127) begin
            s = 127;
            n++;
         end else if (s < -128) begin
            s = -128;
            n++;
         end
      end
   endfunction

   bit m_hold = 1'b0;
   int m_frame[$];
   int m_sum = 0;
   int m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clear) begin
         m_hold = 1'b0;
         m_frame.delete();
         m_sum = 0;
         m_cnt = 0;
      end else if (!m_hold) begin
         if (sif.in_valid) begin
            m_frame.push_back(int'(sif.in_data));
            if (m_frame.size() == FRAME_LEN) begin
               fold(m_frame, m_sum, m_cnt);
               m_hold = 1'b1;
               m_frame.delete();
            end
         end
      end else if (sif.out_ready) begin
         m_hold = 1'b0;
      end
   end

   always @(negedge clk) begin
      check("in_ready", sif.in_ready, rst_n && !m_hold);
      check("out_valid", sif.out_valid, m_hold);
      if (m_hold) begin
         check("out_sum", sif.out_sum, m_sum);
         check("out_ovf", sif.out_ovf, m_cnt > 0);
         check("out_ovf_cnt", sif.out_ovf_cnt, (m_cnt > 15) ? 15 : m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                            input bit rdy, input int e_sum, input int e_ovf, input int e_cnt,
                            input string nm);
      int s[4];
      logic [31:0] w;
      s = '{s0, s1, s2, s3};
      sif.out_ready = rdy;
      for (int i = 0; i < 4; i++) begin
         w = s[i];
         sif.in_valid = 1'b1;
         sif.in_data  = w[7:0];
         tick();
      end
      sif.in_valid = 1'b0;
      check({nm, ".valid"}, sif.out_valid, 1);
      check({nm, ".sum"}, sif.out_sum, e_sum);
      check({nm, ".ovf"}, sif.out_ovf, e_ovf);
      check({nm, ".cnt"}, sif.out_ovf_cnt, e_cnt);
      if (rdy) begin
         tick();
         check({nm, ".one_cycle"}, sif.out_valid, 0);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      clear         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.out_ready = 1'b0;
      repeat (3) tick();
      check("rst.in_ready_low", sif.in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", sif.in_ready, 1);
      check("rst.out_valid", sif.out_valid, 0);
      check("rst.out_sum", sif.out_sum, 0);
      check("rst.out_ovf", sif.out_ovf, 0);
      check("rst.out_cnt", sif.out_ovf_cnt, 0);

      run_frame(10, 20, 30, 40, 1'b1, 100, 0, 0, "plain");
      run_frame(100, 50, -10, -20, 1'b1, 97, 1, 1, "posclamp");
      run_frame(-100, -100, 50, 0, 1'b1, -78, 1, 1, "negclamp");
      run_frame(127, 127, 127, 127, 1'b1, 127, 1, 3, "maxrun");

      // Stall the result and poke the input while held.
      run_frame(1, 2, 3, 4, 1'b0, 10, 0, 0, "stall");
      for (int i = 0; i < 5; i++) begin
         sif.in_valid = 1'($urandom_range(0, 1));
         sif.in_data  = 8'($urandom);
         tick();
         check("stall.valid", sif.out_valid, 1);
         check("stall.sum", sif.out_sum, 10);
         check("stall.in_ready", sif.in_ready, 0);
      end
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      tick();
      check("stall.release", sif.out_valid, 0);
      run_frame(5, 5, 5, 5, 1'b1, 20, 0, 0, "after_stall");

      // Abort mid-frame; the sample presented with clear must be dropped.
      sif.in_valid = 1'b1;
      sif.in_data  = 8'sd50;
      tick();
      tick();
      clear       = 1'b1;
      sif.in_data = 8'sd100;
      tick();
      clear = 1'b0;
      check("clear.in_ready", sif.in_ready, 1);
      run_frame(1, 1, 1, 1, 1'b1, 4, 0, 0, "after_clear");

      // Asynchronous reset while a result is held.
      run_frame(-3, -4, -5, -6, 1'b0, -18, 0, 0, "prereset");
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.out_valid", sif.out_valid, 0);
      check("arst.in_ready", sif.in_ready, 0);
      check("arst.out_sum", sif.out_sum, 0);
      check("arst.out_ovf", sif.out_ovf, 0);
      check("arst.out_cnt", sif.out_ovf_cnt, 0);
      tick();
      rst_n = 1'b1;
      run_frame(7, -7, 60, 70, 1'b1, 127, 1, 1, "after_rst");

      for (int i = 0; i < 600; i++) begin
         sif.in_valid  = ($urandom_range(0, 3) != 0);
         sif.in_data   = 8'($urandom);
         sif.out_ready = ($urandom_range(0, 2) != 0);
         clear         = ($urandom_range(0, 39) == 0);
         tick();
      end
      clear         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
